// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared constants for the PRBS sequencing controller: polynomial select
// encodings, per-polynomial MSB index / feedback tap / width mask, FSM state
// encoding and the default LFSR width.
// Ports: none (package).
package prbs_pkg;

  localparam int LFSR_W_DEF = 31;

  localparam logic [1:0] POLY_7  = 2'b00;  // x^7  + x^6  + 1
  localparam logic [1:0] POLY_15 = 2'b01;  // x^15 + x^14 + 1
  localparam logic [1:0] POLY_23 = 2'b10;  // x^23 + x^18 + 1
  localparam logic [1:0] POLY_31 = 2'b11;  // x^31 + x^28 + 1

  localparam logic [4:0] MSB_7  = 5'd6;
  localparam logic [4:0] MSB_15 = 5'd14;
  localparam logic [4:0] MSB_23 = 5'd22;
  localparam logic [4:0] MSB_31 = 5'd30;

  localparam logic [4:0] TAP_7  = 5'd5;
  localparam logic [4:0] TAP_15 = 5'd13;
  localparam logic [4:0] TAP_23 = 5'd17;
  localparam logic [4:0] TAP_31 = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [4:0] poly_msb(input logic [1:0] poly);
    case (poly)
      POLY_7:  poly_msb = MSB_7;
      POLY_15: poly_msb = MSB_15;
      POLY_23: poly_msb = MSB_23;
      default: poly_msb = MSB_31;
    endcase
  endfunction

  function automatic logic [4:0] poly_tap(input logic [1:0] poly);
    case (poly)
      POLY_7:  poly_tap = TAP_7;
      POLY_15: poly_tap = TAP_15;
      POLY_23: poly_tap = TAP_23;
      default: poly_tap = TAP_31;
    endcase
  endfunction

  function automatic logic [LFSR_W_DEF-1:0] poly_mask(input logic [1:0] poly);
    case (poly)
      POLY_7:  poly_mask = 31'h0000_007F;
      POLY_15: poly_mask = 31'h0000_7FFF;
      POLY_23: poly_mask = 31'h007F_FFFF;
      default: poly_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// prbs_seq_ctrl_if
// Configuration / control / pattern-output bundle of the PRBS sequencer.
// master: config and pin logic (drives cfg_*, start, abort, hold).
// slave : prbs_seq_ctrl (drives cfg_ready, busy, bit_valid, bit_out, done,
//         bit_cnt).
interface prbs_seq_ctrl_if import prbs_pkg::*; #(
  parameter int LFSR_W = LFSR_W_DEF,
  parameter int LEN_W  = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_poly;
  logic [LFSR_W-1:0] cfg_seed;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_inj_en;
  logic [LEN_W-1:0]  cfg_inj_pos;
  logic              start;
  logic              abort;
  logic              hold;
  logic              busy;
  logic              bit_valid;
  logic              bit_out;
  logic              done;
  logic [LEN_W-1:0]  bit_cnt;

  modport master (
    output cfg_valid, cfg_poly, cfg_seed, cfg_len, cfg_inj_en, cfg_inj_pos,
    output start, abort, hold,
    input  cfg_ready, busy, bit_valid, bit_out, done, bit_cnt
  );

  modport slave (
    input  cfg_valid, cfg_poly, cfg_seed, cfg_len, cfg_inj_en, cfg_inj_pos,
    input  start, abort, hold,
    output cfg_ready, busy, bit_valid, bit_out, done, bit_cnt
  );
endinterface

// File: rtl/prbs_lfsr.sv
// prbs_lfsr
// Fibonacci LFSR with run-time polynomial select (PRBS7/15/23/31).
// Ports:
//   clk, rst_n : clock, async active-high reset (state -> 1)
//   load       : load masked seed (zero seed replaced by 1)
//   seed       : seed value, bits at/above the selected width ignored
//   step       : advance one bit
//   poly       : polynomial select
//   msb        : current output bit, state[W-1]
module prbs_lfsr import prbs_pkg::*; #(
  parameter int LFSR_W = LFSR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  input  logic [1:0]        poly,
  output logic              msb
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] mask;
  logic [LFSR_W-1:0] seed_m;
  logic [LFSR_W-1:0] nxt;
  logic [4:0]        msb_idx;
  logic [4:0]        tap_idx;
  logic              fb;

  always_comb begin
    mask    = poly_mask(poly);
    msb_idx = poly_msb(poly);
    tap_idx = poly_tap(poly);
    seed_m  = seed & mask;
    // All-zero is the lock-up state of an XOR LFSR.
    if (seed_m == '0) seed_m = {{(LFSR_W-1){1'b0}}, 1'b1};
    fb  = state_q[msb_idx] ^ state_q[tap_idx];
    // Masking keeps bits above the selected width at zero.
    nxt = {state_q[LFSR_W-2:0], fb} & mask;
  end

  assign msb = state_q[msb_idx];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= {{(LFSR_W-1){1'b0}}, 1'b1};
    end else if (load) begin
      state_q <= seed_m;
    end else if (step) begin
      state_q <= nxt;
    end
  end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl
// Sequencing controller for the on-chip PRBS source: shadow configuration,
// burst FSM, bit counter and single-bit error injection around prbs_lfsr.
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active-high despite the name
//   bus   : prbs_seq_ctrl_if.slave (cfg handshake, start/abort/hold,
//           busy/bit_valid/bit_out/done/bit_cnt)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cfg_ready high, shadow config writable, waits for start
// LOAD  | one cycle: masked seed into LFSR, bit_cnt cleared
// RUN   | bit_valid high, one pattern bit per non-held cycle
// DONE  | one cycle: done pulse, bit_cnt equals programmed length
module prbs_seq_ctrl import prbs_pkg::*; #(
  parameter int LFSR_W = LFSR_W_DEF,
  parameter int LEN_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  prbs_seq_ctrl_if.slave  bus
);

  state_t            state;
  logic [1:0]        sh_poly;
  logic [LFSR_W-1:0] sh_seed;
  logic [LEN_W-1:0]  sh_len;
  logic              sh_inj_en;
  logic [LEN_W-1:0]  sh_inj_pos;
  logic [LEN_W-1:0]  bit_cnt;
  logic              ready_q;
  logic              busy_q;
  logic              valid_q;
  logic              done_q;
  logic              lfsr_msb;
  logic              inj;
  logic              last_bit;
  logic              lfsr_load;
  logic              lfsr_step;

  assign inj       = sh_inj_en & (bit_cnt == sh_inj_pos);
  assign last_bit  = (sh_len != '0) && (bit_cnt == sh_len - LEN_W'(1));
  assign lfsr_load = (state == ST_LOAD);
  assign lfsr_step = (state == ST_RUN) & ~bus.hold;

  prbs_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (sh_seed),
    .step  (lfsr_step),
    .poly  (sh_poly),
    .msb   (lfsr_msb)
  );

  assign bus.cfg_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.bit_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.bit_cnt   = bit_cnt;
  // Injection flips only the emitted bit; the LFSR itself is untouched.
  assign bus.bit_out   = valid_q & (lfsr_msb ^ inj);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      bit_cnt    <= '0;
      sh_poly    <= POLY_31;
      sh_seed    <= {{(LFSR_W-1){1'b0}}, 1'b1};
      sh_len     <= '0;
      sh_inj_en  <= 1'b0;
      sh_inj_pos <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // cfg_ready is high exactly in IDLE, so cfg_valid alone completes
          // the handshake here; a same-cycle start sees the new shadow in LOAD.
          if (bus.cfg_valid) begin
            sh_poly    <= bus.cfg_poly;
            sh_seed    <= bus.cfg_seed;
            sh_len     <= bus.cfg_len;
            sh_inj_en  <= bus.cfg_inj_en;
            sh_inj_pos <= bus.cfg_inj_pos;
          end
          if (bus.start && !bus.abort) begin
            state   <= ST_LOAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          bit_cnt <= '0;
          if (bus.abort) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state   <= ST_RUN;
            valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (!bus.hold) begin
            bit_cnt <= bit_cnt + LEN_W'(1);
            if (last_bit) begin
              state   <= ST_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prbs_seq_ctrl.md
# prbs_seq_ctrl

Sequencing controller for the on-chip PRBS source. It owns one configurable Fibonacci LFSR (PRBS7/15/23/31) and runs it in bounded or continuous bursts from a programmed seed. It supports optional single-bit error injection, flow-control hold and abort. It sits between the configuration/pin logic and the serial test-pattern output pin.

## Interface
Parameters:
- `LFSR_W`, 31: max LFSR width; fixed at 31 for PRBS31 support.
- `LEN_W`, 16: width of burst length, injection position and bit counter.

Ports:
- `clk` in 1: single clock; every register is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-high (asserted when 1, despite the name).
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: config accepted when `cfg_valid & cfg_ready`; high only in IDLE.
- `cfg_poly` in 2: polynomial select. 00 = PRBS7 (x^7+x^6+1), 01 = PRBS15 (x^15+x^14+1), 10 = PRBS23 (x^23+x^18+1), 11 = PRBS31 (x^31+x^28+1).
- `cfg_seed` in LFSR_W: seed; bits at and above the selected width are ignored.
- `cfg_len` in LEN_W: bits per burst; 0 = continuous until abort.
- `cfg_inj_en` in 1: enable error injection.
- `cfg_inj_pos` in LEN_W: 0-based bit index to invert.
- `start` in 1: begin a burst; honoured only in IDLE.
- `abort` in 1: terminate the burst.
- `hold` in 1: stall; freezes LFSR and counter in RUN.
- `busy` out 1: high in LOAD and RUN.
- `bit_valid` out 1: high in RUN.
- `bit_out` out 1: current pattern bit.
- `done` out 1: one-cycle pulse when a bounded burst completes.
- `bit_cnt` out LEN_W: bits emitted in the current or last burst.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `start & !abort` -> LOAD. `abort` has priority, so the block stays in IDLE.
  - A config handshake stores all `cfg_*` fields into shadow registers at that edge.
  - A handshake and `start` in the same cycle: the burst uses the new config.
- **LOAD** (1 cycle)
  - Masked seed loaded into the LFSR; a masked seed of zero is replaced by 1.
  - `bit_cnt` cleared to 0.
  - Next state RUN, or IDLE if `abort`.
- **RUN**
  - `bit_out` = LFSR bit [W-1] XOR `inj`, where `inj` = `cfg_inj_en & (bit_cnt == cfg_inj_pos)`.
  - Injection never alters LFSR state.
  - When `!hold`, each cycle: LFSR <= {s[W-2:0], s[W-1] ^ s[tap]} with tap = 5/13/17/27, and `bit_cnt` += 1, wrapping modulo 2^LEN_W.
  - Bits above W are held at 0.
  - When `cfg_len != 0`, `!hold` and `bit_cnt == cfg_len-1` -> DONE.
  - `abort` -> IDLE with no `done` pulse; `abort` wins over the last-bit transition.
  - `start` is ignored.
- **DONE** (1 cycle)
  - `done` = 1 and `bit_cnt` = `cfg_len`.
  - -> IDLE.
- `bit_cnt` holds its value in IDLE until the next LOAD.
- Reset values:
  - state IDLE; `cfg_ready` = 1.
  - `busy`, `bit_valid`, `bit_out`, `done`, `bit_cnt` = 0.
  - shadow config: poly = 11, seed = 1, len = 0, inj_en = 0, inj_pos = 0.
  - LFSR = 1.
- Reset mid-burst: immediate return to the reset state; no `done` pulse.

## Timing
- All outputs are decoded from registers only; no input-to-output combinational paths.
- `start` high at edge N -> LOAD in cycle N+1 -> first `bit_valid` in cycle N+2, with `bit_out` = MSB of the seed.
- Bounded burst with no hold: `bit_valid` high for exactly `cfg_len` cycles, and `done` appears in the cycle after the last valid bit.
- `hold` high repeats the same `bit_out` with `bit_valid` still 1. The consumer counts a bit only on `bit_valid & !hold`.
- `abort` at edge M: `bit_valid`/`busy` = 0 from cycle M+1.
- `cfg_ready` falls in the cycle after `start` is accepted and rises again in IDLE after DONE or abort.

## Structure
- Shared package `prbs_pkg`:
  - poly-select encodings POLY_7/15/23/31.
  - per-poly width and tap constants.
  - state encoding.
  - `LFSR_W` default.
- Sub-module `prbs_lfsr`:
  - ports: `clk`, `rst_n`, `load`, `seed`, `step`, `poly`, `msb`.
  - contains the masked shift/feedback and the zero-seed substitution.
- The controller holds the FSM, shadow config, counter and injection compare.

## Test plan
- PRBS7, seed 0x7F, len 10, no hold -> bits 1,1,1,1,1,1,1,0 first. Exactly 10 `bit_valid` cycles, `done` one cycle later, `bit_cnt` = 10.
- PRBS7, len 0, continuous for 300 cycles -> sequence repeats with period exactly 127 and never shows 7 consecutive zeros. Then `abort` -> `busy` = 0 next cycle, no `done`.
- PRBS31, seed 0, len 64 -> identical to seed 1. With inj_en, inj_pos 5: only bit 5 differs from a golden model, and bits 6..63 still match it.
- `hold` asserted for 3 cycles at bit 4, len 8 -> bit 4 held 4 cycles. Total `bit_valid` cycles = 11, 8 counted bits matching the golden model.
- Cfg handshake with `start` in the same cycle (poly 01), plus `start` while busy -> new poly used, second `start` ignored. `cfg_ready` = 0 throughout LOAD/RUN/DONE.
- `rst_n` pulsed mid-RUN of PRBS23 -> all outputs to reset values immediately. Next `start` with no new config runs PRBS31 from seed 1.
